// File: rtl/apb_pkg.sv
// Shared APB definitions used by the APB initiator and the APB completers.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_init_state_t;

  // APB4 requires pstrb to be all-zero on reads.
  function automatic logic [APB_STRB_W-1:0] apb_strb_for(input logic write,
                                                         input logic [APB_STRB_W-1:0] strb);
    return write ? strb : '0;
  endfunction

endpackage

// File: rtl/apb_initiator.sv
// Single-outstanding valid/ready request channel to APB4 requester bridge,
// with an access-phase watchdog that aborts transfers the completer never ends.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic [APB_STRB_W-1:0] req_wstrb,
  input  logic [2:0]            req_prot,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [APB_DATA_W-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  resp_timeout,
  output logic [ADDR_W-1:0]     out_paddr,
  output logic                  out_psel,
  output logic                  out_penable,
  output logic [2:0]            out_pprot,
  output logic                  out_pwrite,
  output logic [APB_DATA_W-1:0] out_pwdata,
  output logic [APB_STRB_W-1:0] out_pstrb,
  input  logic                  out_pready,
  input  logic [APB_DATA_W-1:0] out_prdata,
  input  logic                  out_pslverr
);

  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIMIT_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] LIMIT = LIMIT_I[CNT_W-1:0];

  apb_init_state_t  state;
  logic [CNT_W-1:0] wait_cnt;

  // Handshake and APB phase strobes decode straight from the state register.
  assign req_ready   = reset && (state == IDLE);
  assign out_psel    = (state == SETUP) || (state == ACCESS);
  assign out_penable = (state == ACCESS);
  assign resp_valid  = (state == RESP);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      out_paddr    <= '0;
      out_pwrite   <= 1'b0;
      out_pwdata   <= '0;
      out_pstrb    <= '0;
      out_pprot    <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            out_paddr  <= req_addr;
            out_pwrite <= req_write;
            out_pwdata <= req_wdata;
            out_pstrb  <= apb_strb_for(req_write, req_wstrb);
            out_pprot  <= req_prot;
            wait_cnt   <= '0;
            state      <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          // A completion in the watchdog's final cycle still counts as normal.
          if (out_pready) begin
            resp_rdata   <= out_pwrite ? '0 : out_prdata;
            resp_err     <= out_pslverr;
            resp_timeout <= 1'b0;
            state        <= RESP;
          end else if ((TIMEOUT != 0) && (wait_cnt == LIMIT)) begin
            resp_rdata   <= '0;
            resp_err     <= 1'b1;
            resp_timeout <= 1'b1;
            state        <= RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Randomized and directed bench for apb_initiator against a cycle-arithmetic
// transaction model (fire cycle, wait count, timeout limit).
module tb_apb_initiator;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err, resp_timeout;
  logic [31:0] out_paddr;
  logic        out_psel, out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;

  apb_initiator #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_prot(req_prot),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Completer behaviour for the next request, chosen by the driver.
  int          next_w;
  logic [31:0] next_prdata;
  logic        next_slverr;
  int          rr_mode = 0;  // 0: resp_ready high, 1: random, 2: held low

  // Model of the transaction in flight.
  logic        m_busy = 1'b0;
  int          m_fires = 0;
  int          m_t_fire, m_t_resp, m_w;
  logic        m_write, m_to, m_slverr;
  logic [31:0] m_addr, m_wdata, m_prdata;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_prot;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Reference model and per-cycle comparison.
  initial forever begin
    logic e_rr, e_psel, e_pen, e_rv;
    @(negedge clock);
    if (cyc >= 1) begin
      e_rr   = reset && !m_busy;
      e_psel = m_busy && (cyc >= m_t_fire + 1) && (cyc < m_t_resp);
      e_pen  = m_busy && (cyc >= m_t_fire + 2) && (cyc < m_t_resp);
      e_rv   = m_busy && (cyc >= m_t_resp);
      chk("req_ready", req_ready, e_rr);
      chk("psel", out_psel, e_psel);
      chk("penable", out_penable, e_pen);
      chk("resp_valid", resp_valid, e_rv);
      if (e_psel) begin
        chk("paddr", out_paddr, m_addr);
        chk("pwrite", out_pwrite, m_write);
        chk("pwdata", out_pwdata, m_wdata);
        chk("pstrb", out_pstrb, m_write ? m_wstrb : 4'h0);
        chk("pprot", out_pprot, m_prot);
      end
      if (e_rv) begin
        chk("resp_rdata", resp_rdata, (m_to || m_write) ? 32'h0 : m_prdata);
        chk("resp_err", resp_err, m_to || m_slverr);
        chk("resp_timeout", resp_timeout, m_to);
      end
    end
    if (!reset) begin
      m_busy = 1'b0;
    end else if (m_busy && (cyc >= m_t_resp) && resp_ready) begin
      m_busy = 1'b0;
    end else if (!m_busy && req_valid) begin
      m_busy   = 1'b1;
      m_fires++;
      m_t_fire = cyc;
      m_w      = next_w;
      m_to     = (next_w >= TO);
      m_t_resp = m_to ? cyc + 2 + TO : cyc + 3 + next_w;
      m_write  = req_write;
      m_addr   = req_addr;
      m_wdata  = req_wdata;
      m_wstrb  = req_wstrb;
      m_prot   = req_prot;
      m_prdata = next_prdata;
      m_slverr = next_slverr;
    end
  end

  // Completer: pready low for the chosen wait states, high on the completion
  // cycle, random noise everywhere it must be ignored.
  initial forever begin
    @(posedge clock);
    #2;
    if (m_busy && (cyc >= m_t_fire + 2) && (cyc < m_t_fire + 2 + m_w)) begin
      out_pready  = 1'b0;
      out_prdata  = $urandom;
      out_pslverr = 1'($urandom % 2);
    end else if (m_busy && (cyc == m_t_fire + 2 + m_w)) begin
      out_pready  = 1'b1;
      out_prdata  = m_prdata;
      out_pslverr = m_slverr;
    end else begin
      out_pready  = 1'($urandom % 2);
      out_prdata  = $urandom;
      out_pslverr = 1'($urandom % 2);
    end
    case (rr_mode)
      0:       resp_ready = 1'b1;
      2:       resp_ready = 1'b0;
      default: resp_ready = 1'($urandom % 3 != 0);
    endcase
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_fire(input int target);
    int n = 0;
    while (m_fires < target && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (m_fires < target) begin
      checks++;
      errors++;
      $display("FAIL fire_wait: got %0d fires expected %0d", m_fires, target);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (m_busy) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy expected idle");
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input int w, input logic [31:0] rd,
                       input logic slverr);
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wd;
    req_wstrb   = strb;
    req_prot    = 3'($urandom);
    next_w      = w;
    next_prdata = rd;
    next_slverr = slverr;
    req_valid   = 1'b1;
  endtask

  initial begin
    int t, k;
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; req_prot = '0; resp_ready = 1'b1;
    out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
    next_w = 0; next_prdata = '0; next_slverr = 1'b0;

    @(posedge clock);
    #1;
    wait_cyc(2);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_psel", out_psel, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_paddr", out_paddr, 32'h0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(4);
    chk("rst_release_req_ready", req_ready, 1'b1);

    // Write, zero wait states.
    issue(1'b1, 32'hA000_0010, 32'hDEAD_BEEF, 4'h3, 0, 32'h0, 1'b0);
    wait_fire(1);
    req_valid = 1'b0;
    t = m_t_fire;
    chk("w_setup_psel", out_psel, 1'b1);
    chk("w_setup_penable", out_penable, 1'b0);
    chk("w_setup_pstrb", out_pstrb, 4'h3);
    wait_cyc(t + 2);
    chk("w_access_penable", out_penable, 1'b1);
    chk("w_access_resp_valid", resp_valid, 1'b0);
    wait_cyc(t + 3);
    chk("w_resp_valid", resp_valid, 1'b1);
    chk("w_resp_err", resp_err, 1'b0);
    chk("w_resp_rdata", resp_rdata, 32'h0);
    wait_idle();

    // Read, three wait states.
    issue(1'b0, 32'h4, 32'h5555_AAAA, 4'hF, 3, 32'h1234_5678, 1'b0);
    wait_fire(2);
    req_valid = 1'b0;
    t = m_t_fire;
    for (int i = 2; i < 6; i++) begin
      wait_cyc(t + i);
      chk("r_access_pstrb", out_pstrb, 4'h0);
      chk("r_access_paddr", out_paddr, 32'h4);
      chk("r_access_penable", out_penable, 1'b1);
    end
    wait_cyc(t + 6);
    chk("r_resp_valid", resp_valid, 1'b1);
    chk("r_resp_rdata", resp_rdata, 32'h1234_5678);
    wait_idle();

    // Read completing with pslverr.
    issue(1'b0, 32'h100, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1'b1);
    wait_fire(3);
    req_valid = 1'b0;
    t = m_t_fire;
    wait_cyc(t + 4);
    chk("slverr_resp_err", resp_err, 1'b1);
    chk("slverr_resp_timeout", resp_timeout, 1'b0);
    wait_idle();

    // Completer never responds: watchdog abort.
    issue(1'b0, 32'h200, 32'h0, 4'h0, 100, 32'h0, 1'b0);
    wait_fire(4);
    req_valid = 1'b0;
    t = m_t_fire;
    wait_cyc(t + 9);
    chk("to_pre_resp_valid", resp_valid, 1'b0);
    chk("to_pre_psel", out_psel, 1'b1);
    wait_cyc(t + 10);
    chk("to_resp_valid", resp_valid, 1'b1);
    chk("to_resp_err", resp_err, 1'b1);
    chk("to_resp_timeout", resp_timeout, 1'b1);
    chk("to_resp_rdata", resp_rdata, 32'h0);
    chk("to_psel", out_psel, 1'b0);
    wait_idle();

    // Response back-pressure with a second request waiting.
    rr_mode = 2;
    issue(1'b1, 32'h300, 32'h1111_2222, 4'hC, 0, 32'h0, 1'b0);
    wait_fire(5);
    t = m_t_fire;
    issue(1'b0, 32'h304, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 1'b0);
    for (int i = 3; i < 8; i++) begin
      wait_cyc(t + i);
      chk("bp_resp_valid", resp_valid, 1'b1);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    wait_cyc(t + 8);
    rr_mode = 0;
    wait_cyc(t + 9);
    chk("bp_next_req_ready", req_ready, 1'b1);
    wait_cyc(t + 10);
    chk("bp_next_psel", out_psel, 1'b1);
    chk("bp_next_penable", out_penable, 1'b0);
    req_valid = 1'b0;
    wait_idle();

    // Reset during the access phase.
    issue(1'b1, 32'h400, 32'h7777_8888, 4'hF, 100, 32'h0, 1'b0);
    wait_fire(7);
    req_valid = 1'b0;
    t = m_t_fire;
    wait_cyc(t + 3);
    reset = 1'b0;
    wait_cyc(t + 4);
    chk("mid_rst_psel", out_psel, 1'b0);
    chk("mid_rst_penable", out_penable, 1'b0);
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b0);
    chk("mid_rst_paddr", out_paddr, 32'h0);
    chk("mid_rst_pwdata", out_pwdata, 32'h0);
    wait_cyc(t + 5);
    reset = 1'b1;
    issue(1'b1, 32'h500, 32'h0102_0304, 4'h5, 1, 32'h0, 1'b0);
    wait_fire(8);
    req_valid = 1'b0;
    t = m_t_fire;
    wait_cyc(t + 4);
    chk("post_rst_resp_valid", resp_valid, 1'b1);
    chk("post_rst_resp_err", resp_err, 1'b0);
    wait_idle();

    // Randomized traffic, including back-to-back requests and timeouts.
    rr_mode = 1;
    k = 8;
    for (int n = 0; n < 60; n++) begin
      int w;
      w = ($urandom % 4 == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 3));
      issue(1'($urandom % 2), $urandom, $urandom, 4'($urandom), w, $urandom,
            1'($urandom % 4 == 0));
      k++;
      wait_fire(k);
      if ($urandom % 2 == 0) begin
        req_valid = 1'b0;
        wait_cyc(cyc + int'($urandom_range(0, 2)));
      end
    end
    req_valid = 1'b0;
    wait_idle();
    wait_cyc(cyc + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
# apb_initiator

Converts a single-outstanding valid/ready request/response channel into APB4 requester transfers. It sits between an internal master (a debug port, DMA or test engine) and the APB fabric that serves peripherals such as the SDRAM completer. It drives setup and access phases, holds the bus through wait states and captures `prdata`/`pslverr`. A watchdog ends the wait and reports an error if the completer never raises `pready`.

## Interface
- `ADDR_W`, 32: request and APB address width
- `TIMEOUT`, 1024: maximum access-phase cycles with `pready`=0 before abort; 0 disables the watchdog
- `clock` in 1: the only clock
- `reset` in 1: synchronous, active-low (0 = reset), sampled on `posedge clock`
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when `req_valid && req_ready`
- `req_write` in 1: 1 = write, 0 = read
- `req_addr` in ADDR_W: byte address
- `req_wdata` in 32: write data
- `req_wstrb` in 4: write byte strobes
- `req_prot` in 3: forwarded to `pprot`
- `resp_valid` out 1: response present
- `resp_ready` in 1: response consumed when `resp_valid && resp_ready`
- `resp_rdata` out 32: read data; 0 for writes and timeouts
- `resp_err` out 1: `pslverr` from the completer, or timeout
- `resp_timeout` out 1: error was caused by the watchdog
- `out_paddr` out ADDR_W, `out_psel` out 1, `out_penable` out 1, `out_pprot` out 3, `out_pwrite` out 1, `out_pwdata` out 32, `out_pstrb` out 4: APB requester outputs
- `out_pready` in 1, `out_prdata` in 32, `out_pslverr` in 1: APB completer returns

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On fire: latch all request fields into holding registers and go to SETUP.
  - Read requests latch `pstrb`=0 regardless of `req_wstrb`, per the APB4 read rule.
- SETUP:
  - `psel`=1, `penable`=0, address/control/data driven from the holding registers.
  - Always advance to ACCESS next cycle.
- ACCESS:
  - `psel`=1, `penable`=1; all APB outputs stay stable.
  - If `pready`=1: capture `prdata` (reads only, else 0) and `pslverr` into the response registers, `resp_timeout`=0, go to RESP.
  - Else if `TIMEOUT`≠0 and the wait counter equals `TIMEOUT`-1: set `resp_err`=1, `resp_timeout`=1, `resp_rdata`=0, go to RESP. `psel` drops on the next cycle.
  - Else increment the wait counter.
  - The counter is cleared on entry to SETUP.
  - Counter width is `$clog2(TIMEOUT+1)`, minimum 1. It saturates and never wraps.
- RESP:
  - `resp_valid`=1, `psel`=`penable`=0, `req_ready`=0.
  - On `resp_ready`, go to IDLE.
  - Response fields stay stable until they are consumed.
- `pready` is ignored outside ACCESS.
- `resp_ready` is ignored outside RESP.
- Only one transfer is outstanding at a time; there is no pipelining.
- Holding registers are updated only on request fire. APB outputs therefore never change between SETUP and the end of ACCESS.

## Timing
- Reset values: state IDLE, `req_ready`=1 while `reset`=1 in IDLE, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `resp_timeout`=0, `out_psel`=0, `out_penable`=0, `out_paddr`=0, `out_pwrite`=0, `out_pwdata`=0, `out_pstrb`=0, `out_pprot`=0, wait counter 0.
- `req_ready` and `out_psel` during the reset cycle are 0.
- With the request firing at cycle N:
  - SETUP at N+1.
  - ACCESS at N+2 and onward.
  - If `pready` is first sampled high at cycle N+2+W, `resp_valid` is asserted at N+3+W.
- Minimum request-to-response latency: 3 cycles.
- Minimum request-to-request spacing: 4 cycles when `resp_ready` is held high.
- Timeout with no `pready`: `resp_valid` is asserted at N+2+`TIMEOUT`.
- Reset asserted mid-transfer: the next cycle is in IDLE with all outputs at their reset values and no response delivered. The abandoned completer sees `psel` drop.
- `pready` and the timeout reaching its limit in the same cycle: `pready` wins, giving a normal completion with `resp_timeout`=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from the `req_*`, `resp_ready` or `out_p*` inputs to any output.

## Structure
- Shared package `apb_pkg`:
  - State enum `apb_init_state_t` {IDLE, SETUP, ACCESS, RESP}, 2 bits.
  - Constants `APB_DATA_W`=32 and `APB_STRB_W`=4.
  - The same package is used by the APB completers.
- Single flat module. The watchdog counter is inline; no sub-module.

## Test plan
- Write `addr`=0xA000_0010, `wdata`=0xDEAD_BEEF, `wstrb`=0x3, `pready` high in the first access cycle:
  - `psel`=1 with `penable`=0 one cycle, then `penable`=1 one cycle, with `pstrb`=0x3.
  - `resp_valid` 3 cycles after fire, `resp_err`=0, `resp_rdata`=0.
- Read `addr`=0x4, `wstrb`=0xF, 3 wait states, `prdata`=0x1234_5678:
  - `pstrb`=0, APB outputs stable for 4 access cycles.
  - `resp_rdata`=0x1234_5678 at fire+6.
- Read completing with `pslverr`=1: `resp_err`=1, `resp_timeout`=0.
- `TIMEOUT`=8, `pready` never asserted:
  - `resp_valid` at fire+10 with `resp_err`=1, `resp_timeout`=1, `resp_rdata`=0.
  - `psel`=0 the same cycle.
- `resp_ready` held low 5 cycles with a second `req_valid` pending:
  - Response fields stable, `req_ready`=0.
  - The second request fires the cycle after the response handshake.
- `reset`=0 during ACCESS:
  - Next cycle `psel`=0, `penable`=0, `resp_valid`=0, `req_ready`=0.
  - After release, a new transfer completes normally.
